// File: rtl/f1_sequencer.sv
// F1 start-light sequencer: lights LEDs one by one using an external delay
// counter, holds all lit for a random interval, then blanks them together.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   start    - begin a sequence when idle
//   rand_n   - count limit for the final random hold
//   time_out - expiry flag from the delay counter
//   N        - count limit presented to the delay counter
//   trigger  - delay counter run (1) / clear (0)
//   ledr     - light bank, bit 0 lights first
//   busy     - high whenever not idle
//   done     - one-cycle pulse when the lights go out
module f1_sequencer #(
    parameter int          LIGHTS = 10,
    parameter logic [15:0] STEP_N = 16'd49999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       rand_n,
    input  logic              time_out,
    output logic [15:0]       N,
    output logic              trigger,
    output logic [LIGHTS-1:0] ledr,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(LIGHTS + 1);

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        GAP,
        HOLD,
        OFF
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [15:0]       n_q;
    logic              trig_q;
    logic [LIGHTS-1:0] ledr_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            trig_q  <= 1'b0;
            ledr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= STEP;
                        n_q     <= STEP_N;
                        cnt_q   <= '0;
                        trig_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        ledr_q  <= '0;
                    end
                end
                STEP: begin
                    if (time_out) begin
                        state_q <= GAP;
                        trig_q  <= 1'b0;
                        ledr_q  <= {ledr_q[LIGHTS-2:0], 1'b1};
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                // One clear cycle so the delay counter restarts from zero;
                // its time_out here is stale and deliberately ignored.
                GAP: begin
                    trig_q <= 1'b1;
                    if (cnt_q == CW'(LIGHTS)) begin
                        state_q <= HOLD;
                        n_q     <= rand_n;
                    end else begin
                        state_q <= STEP;
                        n_q     <= STEP_N;
                    end
                end
                HOLD: begin
                    if (time_out) begin
                        state_q <= OFF;
                        trig_q  <= 1'b0;
                        ledr_q  <= '0;
                        done_q  <= 1'b1;
                    end
                end
                OFF: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    trig_q  <= 1'b0;
                    ledr_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign N       = n_q;
    assign trigger = trig_q;
    assign ledr    = ledr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: doc/f1_sequencer.md
F1_SEQUENCER -- requirements
Module: f1_sequencer

Interface
REQ-001 SHALL have parameter LIGHTS, default 10, meaning number of LEDs lit in sequence (range 2..16).
REQ-002 SHALL have parameter STEP_N, default 16'd49999, meaning the count limit driven on N for each light step.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  begins a sequence when sampled high in IDLE.
REQ-006 SHALL have port rand_n  input  16  count limit for the final random hold; sampled once per sequence.
REQ-007 SHALL have port time_out  input  1  expiry flag from the delay counter being driven.
REQ-008 SHALL have port N  output  16  count limit presented to the delay counter.
REQ-009 SHALL have port trigger  output  1  delay run/clear; high = count, low = clear.
REQ-010 SHALL have port ledr  output  LIGHTS  light bank; bit 0 lights first.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the lights go out.

Function
REQ-013 SHALL implement states IDLE, STEP, GAP, HOLD, OFF; all outputs registered.
REQ-014 IDLE: trigger=0, ledr=0, done=0; start=1 -> STEP with N=STEP_N, step counter=0.
REQ-015 STEP: trigger=1; on time_out=1 -> GAP, ledr <= {ledr[LIGHTS-2:0],1'b1}, step counter +1.
REQ-016 GAP: trigger=0 for exactly one cycle; time_out is ignored in GAP (stale value).
REQ-017 GAP exit: step counter < LIGHTS -> STEP with N=STEP_N; step counter == LIGHTS -> HOLD with N=rand_n sampled on that edge.
REQ-018 HOLD: trigger=1, ledr all ones; on time_out=1 -> OFF.
REQ-019 OFF: one cycle; ledr=0, trigger=0, done=1; then -> IDLE with done=0.
REQ-020 N SHALL be stable for the whole interval trigger is high; rand_n changes after sampling have no effect.
REQ-021 rand_n=0 SHALL be passed unchanged; no clamping.
REQ-022 start while busy=1 SHALL be ignored; start held high through OFF SHALL begin a new sequence on the IDLE cycle.
REQ-023 time_out=1 while trigger=0 SHALL never advance state.
REQ-024 Step period, with a delay counter that asserts time_out on the edge where its count equals N: STEP_N+3 cycles per light.
REQ-025 Step counter width SHALL be ceil(log2(LIGHTS+1)); no wrap within a sequence.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, N=0, trigger=0, ledr=0, busy=0, done=0 and clear the step counter; it has priority over all inputs.
REQ-027 rst asserted mid-sequence SHALL abort with no done pulse; the first start after rst release begins a fresh sequence from ledr=0.

Verification
REQ-028 Reset: rst=1 for 2 cycles with start=1 -> N=0, trigger=0, ledr=0, busy=0, done=0 on every cycle.
REQ-029 Full run with a behavioral delay counter, LIGHTS=10, STEP_N=3, rand_n=5 -> ledr 0x001, 0x003 … 0x3FF at 6-cycle spacing. Then ledr=0x000 and a single-cycle done, 8 cycles after 0x3FF. busy then drops.
REQ-030 Handshake: trigger low for exactly 1 cycle between intervals, and time_out forced high during GAP -> no extra light.
REQ-031 start pulsed at ledr=0x007 -> sequence unaffected. rand_n changed from 5 to 200 during HOLD -> N stays 5.
REQ-032 rst pulsed for 1 cycle at ledr=0x01F -> next cycle IDLE, ledr=0, no done. A later start -> first light 0x001.
REQ-033 rand_n=0 -> HOLD lasts 3 cycles, then OFF with done=1.
